// File: rtl/cpu_mon_pkg.sv
// Shared encodings for the CPU run monitor: halt causes, FSM states, syscall
// opcode and trace-entry layout {pc, wb_addr, wb_data}.
package cpu_mon_pkg;

    typedef enum logic [1:0] {
        HALT_NONE    = 2'd0,
        HALT_SYSCALL = 2'd1,
        HALT_LOOP    = 2'd2,
        HALT_TIMEOUT = 2'd3
    } halt_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mon_state_e;

    localparam logic [31:0] SYSCALL_INSTR = 32'h0000000C;
    localparam int          WB_ADDR_W     = 5;
    localparam int          TRACE_DATA_LSB = 0;

    function automatic int trace_w(input int pc_w, input int data_w);
        return pc_w + WB_ADDR_W + data_w;
    endfunction

    function automatic int trace_addr_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int trace_pc_lsb(input int data_w);
        return data_w + WB_ADDR_W;
    endfunction

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous show-ahead FIFO for the writeback trace. Full-push behaviour is
// selected by CPU_RUN_MONITOR_TRACE_WRAP_EN (overwrite oldest) vs. drop newest.
module trace_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_pop;
    logic             do_write;

    assign empty  = (wptr_q == rptr_q);
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop = pop && !empty;
    assign rdata  = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        do_write = 1'b0;
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push) begin
            if (!full || do_pop) begin
                do_write = 1'b1;
                wptr_d   = wptr_q + 1'b1;
            end else begin
`ifdef CPU_RUN_MONITOR_TRACE_WRAP_EN
                // Write lands on the oldest slot; drag the read side past it.
                do_write = 1'b1;
                wptr_d   = wptr_q + 1'b1;
                rptr_d   = rptr_q + 1'b1;
`endif
            end
        end
        if (clear) begin
            wptr_d   = '0;
            rptr_d   = '0;
            do_write = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor for the single-cycle CPU: IDLE/RUN/DONE FSM, halt detection,
// cycle/instruction counters and a writeback trace FIFO (CPU_RUN_MONITOR_TRACE_WRAP_EN).
module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int MAX_CYCLES  = 1024,
    parameter int LOOP_LIMIT  = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [PC_W-1:0]                   pc_in,
    input  logic [31:0]                       instr_in,
    input  logic                              wb_en,
    input  logic [WB_ADDR_W-1:0]              wb_addr,
    input  logic [DATA_W-1:0]                 wb_data,
    input  logic                              rd_en,
    output logic [PC_W+WB_ADDR_W+DATA_W-1:0]  rd_data,
    output logic                              empty,
    output logic                              overflow,
    output logic                              running,
    output logic                              done,
    output logic [1:0]                        halt_cause,
    output logic [31:0]                       cycle_count,
    output logic [31:0]                       instr_count
);
    localparam int TW       = trace_w(PC_W, DATA_W);
    localparam int ADDR_LSB = trace_addr_lsb(DATA_W);
    localparam int PC_LSB   = trace_pc_lsb(DATA_W);
    localparam int LCW      = $clog2(LOOP_LIMIT + 1);

    mon_state_e       state_q, state_d;
    halt_cause_e      cause_q, cause_d;
    logic [31:0]      cyc_q, cyc_d;
    logic [31:0]      ins_q, ins_d;
    logic [LCW-1:0]   loop_q, loop_d;
    logic [PC_W-1:0]  prev_pc_q, prev_pc_d;
    logic             prev_vld_q, prev_vld_d;
    logic             ovf_q, ovf_d;

    logic             pc_same;
    logic             hit_sys, hit_loop, hit_to;
    logic             push, fifo_clear, fifo_full;
    logic [TW-1:0]    trace_entry;

    assign pc_same  = prev_vld_q && (pc_in == prev_pc_q);
    assign hit_sys  = (instr_in == SYSCALL_INSTR);
    assign hit_loop = pc_same && (loop_q == LCW'(LOOP_LIMIT - 1));
    assign hit_to   = (cyc_q == 32'(MAX_CYCLES - 1));
    assign push     = (state_q == ST_RUN) && wb_en && (wb_addr != '0);

    always_comb begin
        trace_entry = '0;
        trace_entry[TRACE_DATA_LSB +: DATA_W]  = wb_data;
        trace_entry[ADDR_LSB +: WB_ADDR_W]     = wb_addr;
        trace_entry[PC_LSB +: PC_W]            = pc_in;
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        cyc_d      = cyc_q;
        ins_d      = ins_q;
        loop_d     = loop_q;
        prev_pc_d  = prev_pc_q;
        prev_vld_d = prev_vld_q;
        ovf_d      = ovf_q;
        fifo_clear = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_RUN;
                    cause_d    = HALT_NONE;
                    cyc_d      = '0;
                    ins_d      = '0;
                    loop_d     = '0;
                    prev_vld_d = 1'b0;
                    ovf_d      = 1'b0;
                    fifo_clear = 1'b1;
                end
            end
            ST_RUN: begin
                cyc_d      = sat_inc(cyc_q);
                prev_pc_d  = pc_in;
                prev_vld_d = 1'b1;
                if (prev_vld_q && !pc_same) begin
                    ins_d = sat_inc(ins_q);
                end
                loop_d = pc_same ? loop_q + 1'b1 : '0;
                // A concurrent pop frees a slot, so only an unpopped full push loses data.
                if (push && fifo_full && !rd_en) begin
                    ovf_d = 1'b1;
                end
                if (hit_sys) begin
                    state_d = ST_DONE;
                    cause_d = HALT_SYSCALL;
                end else if (hit_loop) begin
                    state_d = ST_DONE;
                    cause_d = HALT_LOOP;
                end else if (hit_to) begin
                    state_d = ST_DONE;
                    cause_d = HALT_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cause_q    <= HALT_NONE;
            cyc_q      <= '0;
            ins_q      <= '0;
            loop_q     <= '0;
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            cyc_q      <= cyc_d;
            ins_q      <= ins_d;
            loop_q     <= loop_d;
            prev_pc_q  <= prev_pc_d;
            prev_vld_q <= prev_vld_d;
            ovf_q      <= ovf_d;
        end
    end

    trace_fifo #(
        .WIDTH (TW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (fifo_clear),
        .push  (push),
        .pop   (rd_en),
        .wdata (trace_entry),
        .rdata (rd_data),
        .empty (empty),
        .full  (fifo_full)
    );

    assign running     = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign overflow    = ovf_q;
    assign halt_cause  = cause_q;
    assign cycle_count = cyc_q;
    assign instr_count = ins_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: two instances (long and short cycle budget) share one
// stimulus stream and are checked against a per-run outcome model.
module tb_cpu_run_monitor;
    localparam int PC_W = 32, DATA_W = 32, DEPTH = 16, LOOP_LIMIT = 4;
    localparam int TW = PC_W + 5 + DATA_W;
    localparam int MAXC0 = 64, MAXC1 = 16, MAXN = 48;
    localparam logic [31:0] SYS = 32'h0000000C;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, wb_en = 1'b0, rd_en = 1'b0;
    logic [31:0] pc_in = '0, instr_in = '0, wb_data = '0;
    logic [4:0]  wb_addr = '0;

    logic [TW-1:0] rd_data_w [2];
    logic          empty_w [2], ovf_w [2], run_w [2], done_w [2];
    logic [1:0]    cause_w [2];
    logic [31:0]   cyc_w [2], ins_w [2];

    int checks = 0, errors = 0;

    logic [31:0] s_pc [MAXN], s_instr [MAXN], s_data [MAXN];
    logic [4:0]  s_addr [MAXN];
    bit          s_wb [MAXN], s_pop [MAXN];
    int          s_len;

    int            exp_cause [2], exp_cyc [2], exp_ins [2];
    bit            exp_ovf [2];
    logic [TW-1:0] exp_q0 [$], exp_q1 [$];

    always #5 clk = ~clk;

    cpu_run_monitor #(.PC_W(PC_W), .DATA_W(DATA_W), .TRACE_DEPTH(DEPTH),
                      .MAX_CYCLES(MAXC0), .LOOP_LIMIT(LOOP_LIMIT)) dut0 (
        .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .instr_in(instr_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .rd_en(rd_en),
        .rd_data(rd_data_w[0]), .empty(empty_w[0]), .overflow(ovf_w[0]),
        .running(run_w[0]), .done(done_w[0]), .halt_cause(cause_w[0]),
        .cycle_count(cyc_w[0]), .instr_count(ins_w[0]));

    cpu_run_monitor #(.PC_W(PC_W), .DATA_W(DATA_W), .TRACE_DEPTH(DEPTH),
                      .MAX_CYCLES(MAXC1), .LOOP_LIMIT(LOOP_LIMIT)) dut1 (
        .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .instr_in(instr_in),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .rd_en(rd_en),
        .rd_data(rd_data_w[1]), .empty(empty_w[1]), .overflow(ovf_w[1]),
        .running(run_w[1]), .done(done_w[1]), .halt_cause(cause_w[1]),
        .cycle_count(cyc_w[1]), .instr_count(ins_w[1]));

    task automatic clear_stim();
        s_len = 0;
        for (int k = 0; k < MAXN; k++) begin
            s_pc[k] = '0; s_instr[k] = '0; s_data[k] = '0; s_addr[k] = '0;
            s_wb[k] = 1'b0; s_pop[k] = 1'b0;
        end
    endtask

    // Outcome of a whole run: walk the program until the first halt rule fires.
    task automatic model(input int d, input int maxc);
        logic [TW-1:0] q [$];
        int eq_run, cause, cyc, ins;
        bit ovf, same;
        eq_run = 0; cause = 0; cyc = 0; ins = 0; ovf = 1'b0;
        for (int k = 0; k < s_len; k++) begin
            same = (k > 0) && (s_pc[k] == s_pc[k-1]);
            eq_run = same ? eq_run + 1 : 0;
            if (k > 0 && !same) ins++;
            if (s_wb[k] && s_addr[k] != 0) begin
                if (q.size() < DEPTH) q.push_back({s_pc[k], s_addr[k], s_data[k]});
                else begin
                    ovf = 1'b1;
`ifdef CPU_RUN_MONITOR_TRACE_WRAP_EN
                    void'(q.pop_front());
                    q.push_back({s_pc[k], s_addr[k], s_data[k]});
`endif
                end
            end
            cyc = k + 1;
            if (s_instr[k] == SYS) cause = 1;
            else if (eq_run >= LOOP_LIMIT) cause = 2;
            else if (k == maxc - 1) cause = 3;
            if (cause != 0) break;
        end
        exp_cause[d] = cause; exp_cyc[d] = cyc; exp_ins[d] = ins; exp_ovf[d] = ovf;
        if (d == 0) exp_q0 = q; else exp_q1 = q;
    endtask

    task automatic drive_run();
        bit fin;
        fin = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < s_len; k++) begin
            pc_in = s_pc[k]; instr_in = s_instr[k]; wb_en = s_wb[k];
            wb_addr = s_addr[k]; wb_data = s_data[k]; rd_en = s_pop[k];
            @(negedge clk);
            if (done_w[0] && done_w[1]) begin fin = 1'b1; break; end
        end
        wb_en = 1'b0; rd_en = 1'b0; instr_in = '0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL run_bound: done0=%0b done1=%0b, required both done", done_w[0], done_w[1]);
        end
    endtask

    task automatic verify_against_model(input string tag);
        logic [TW-1:0] e;
        int n;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (done_w[d] !== 1'b1 || run_w[d] !== 1'b0 || cause_w[d] !== 2'(exp_cause[d])) begin
                errors++;
                $display("FAIL %s_status[%0d]: done=%0b run=%0b cause=%0d, required 1 0 %0d",
                         tag, d, done_w[d], run_w[d], cause_w[d], exp_cause[d]);
            end
            checks++;
            if (cyc_w[d] !== 32'(exp_cyc[d]) || ins_w[d] !== 32'(exp_ins[d])) begin
                errors++;
                $display("FAIL %s_counts[%0d]: cyc=%0d ins=%0d, required %0d %0d",
                         tag, d, cyc_w[d], ins_w[d], exp_cyc[d], exp_ins[d]);
            end
            checks++;
            if (ovf_w[d] !== exp_ovf[d]) begin
                errors++;
                $display("FAIL %s_ovf[%0d]: got %0b, required %0b", tag, d, ovf_w[d], exp_ovf[d]);
            end
        end
        rd_en = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            for (int d = 0; d < 2; d++) begin
                n = (d == 0) ? exp_q0.size() : exp_q1.size();
                if (i < n) begin
                    e = (d == 0) ? exp_q0[i] : exp_q1[i];
                    checks++;
                    if (rd_data_w[d] !== e || empty_w[d] !== 1'b0) begin
                        errors++;
                        $display("FAIL %s_trace[%0d][%0d]: got %h empty=%0b, required %h",
                                 tag, d, i, rd_data_w[d], empty_w[d], e);
                    end
                end else if (i == n) begin
                    checks++;
                    if (empty_w[d] !== 1'b1 || rd_data_w[d] !== '0) begin
                        errors++;
                        $display("FAIL %s_drain[%0d]: empty=%0b data=%h after %0d pops, required empty",
                                 tag, d, empty_w[d], rd_data_w[d], n);
                    end
                end
            end
            @(negedge clk);
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({run_w[d], done_w[d], ovf_w[d], empty_w[d], cause_w[d]} !== 6'b000100 ||
                cyc_w[d] !== 0 || ins_w[d] !== 0 || rd_data_w[d] !== '0) begin
                errors++;
                $display("FAIL reset[%0d]: run=%0b done=%0b ovf=%0b empty=%0b cause=%0d cyc=%0d ins=%0d",
                         d, run_w[d], done_w[d], ovf_w[d], empty_w[d], cause_w[d], cyc_w[d], ins_w[d]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic load_syscall_prog();
        clear_stim();
        s_len = 4;
        for (int k = 0; k < 3; k++) begin
            s_pc[k] = 32'(k * 4); s_instr[k] = 32'h00000020 + 32'(k);
            s_wb[k] = 1'b1; s_addr[k] = 5'(k + 1); s_data[k] = 32'(100 + k);
        end
        s_pc[3] = 32'd12; s_instr[3] = SYS;
    endtask

    task automatic test_syscall();
        load_syscall_prog();
        model(0, MAXC0); model(1, MAXC1);
        drive_run();
        checks++;
        if (cause_w[0] !== 2'd1 || ins_w[0] !== 32'd3 || cyc_w[0] !== 32'd4) begin
            errors++;
            $display("FAIL syscall_direct: cause=%0d ins=%0d cyc=%0d, required 1 3 4",
                     cause_w[0], ins_w[0], cyc_w[0]);
        end
        verify_against_model("syscall");
    endtask

    task automatic test_loop();
        clear_stim();
        s_len = 16;
        for (int k = 0; k < s_len; k++) begin
            s_pc[k] = (k < 5) ? 32'(k * 4) : 32'd20;
            s_wb[k] = 1'b1; s_addr[k] = 5'((k % 31) + 1); s_data[k] = 32'(k);
        end
        s_instr[15] = SYS;
        model(0, MAXC0); model(1, MAXC1);
        drive_run();
        checks++;
        if (cause_w[0] !== 2'd2 || cyc_w[0] !== 32'd10 || ins_w[0] !== 32'd5) begin
            errors++;
            $display("FAIL loop_direct: cause=%0d cyc=%0d ins=%0d, required 2 10 5",
                     cause_w[0], cyc_w[0], ins_w[0]);
        end
        verify_against_model("loop");
    endtask

    task automatic test_timeout();
        clear_stim();
        s_len = 40;
        for (int k = 0; k < s_len; k++) begin
            s_pc[k] = 32'(k * 4); s_wb[k] = 1'b1;
            s_addr[k] = 5'($urandom_range(1, 31)); s_data[k] = $urandom;
        end
        s_instr[39] = SYS;
        model(0, MAXC0); model(1, MAXC1);
        drive_run();
        repeat (5) @(negedge clk);
        checks++;
        if (cause_w[1] !== 2'd3 || cyc_w[1] !== 32'd16 || done_w[1] !== 1'b1) begin
            errors++;
            $display("FAIL timeout_stable: cause=%0d cyc=%0d done=%0b, required 3 16 1",
                     cause_w[1], cyc_w[1], done_w[1]);
        end
        verify_against_model("timeout");
        s_len = 16; s_instr[15] = SYS;
        model(0, MAXC0); model(1, MAXC1);
        drive_run();
        checks++;
        if (cause_w[1] !== 2'd1 || cyc_w[1] !== 32'd16) begin
            errors++;
            $display("FAIL timeout_vs_syscall: cause=%0d cyc=%0d, required 1 16", cause_w[1], cyc_w[1]);
        end
        verify_against_model("to_sys");
    endtask

    task automatic test_overflow();
        logic [31:0] first_exp;
        clear_stim();
        s_len = 22;
        for (int k = 0; k < 21; k++) begin
            s_pc[k] = 32'(k * 4); s_wb[k] = 1'b1;
            s_addr[k] = (k == 10) ? 5'd0 : 5'd7;
            s_data[k] = (k == 10) ? 32'd999 : ((k < 10) ? 32'(k + 1) : 32'(k));
        end
        s_pc[21] = 32'd84; s_instr[21] = SYS;
        model(0, MAXC0); model(1, MAXC1);
        drive_run();
`ifdef CPU_RUN_MONITOR_TRACE_WRAP_EN
        first_exp = 32'd5;
`else
        first_exp = 32'd1;
`endif
        checks++;
        if (ovf_w[0] !== 1'b1 || rd_data_w[0][31:0] !== first_exp) begin
            errors++;
            $display("FAIL overflow_direct: ovf=%0b head=%0d, required 1 %0d",
                     ovf_w[0], rd_data_w[0][31:0], first_exp);
        end
        verify_against_model("overflow");
    endtask

    task automatic test_back_to_back();
        clear_stim();
        s_len = 18;
        for (int k = 0; k < 17; k++) begin
            s_pc[k] = 32'(k * 4); s_wb[k] = 1'b1; s_addr[k] = 5'd3; s_data[k] = 32'(100 + k);
        end
        s_pop[16] = 1'b1;
        s_pc[17] = 32'd68; s_instr[17] = SYS;
        model(0, MAXC0); model(1, MAXC1);
        // dut0 sees the pop alongside the 17th push; dut1 is already halted and just pops.
        exp_q0.delete();
        for (int k = 1; k < 17; k++) exp_q0.push_back({32'(k * 4), 5'd3, 32'(100 + k)});
        exp_ovf[0] = 1'b0;
        void'(exp_q1.pop_front());
        drive_run();
        checks++;
        if (ovf_w[0] !== 1'b0 || empty_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL push_pop_full: ovf=%0b empty=%0b, required 0 0", ovf_w[0], empty_w[0]);
        end
        verify_against_model("push_pop");
    endtask

    task automatic test_reset_mid_run();
        load_syscall_prog();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pc_in = 32'(k * 4); instr_in = '0; wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'(k);
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({run_w[0], done_w[0], ovf_w[0], empty_w[0], cause_w[0]} !== 6'b000100 ||
            cyc_w[0] !== 0 || ins_w[0] !== 0 || rd_data_w[0] !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: run=%0b done=%0b empty=%0b cyc=%0d ins=%0d, required reset values",
                     run_w[0], done_w[0], empty_w[0], cyc_w[0], ins_w[0]);
        end
        wb_en = 1'b0;
        @(negedge clk); reset = 1'b0;
        model(0, MAXC0); model(1, MAXC1);
        drive_run();
        checks++;
        if (cyc_w[0] !== 32'd4 || ins_w[0] !== 32'd3) begin
            errors++;
            $display("FAIL rerun_counts: cyc=%0d ins=%0d, required 4 3", cyc_w[0], ins_w[0]);
        end
        verify_against_model("rerun");
    endtask

    task automatic test_random();
        logic [31:0] pc;
        for (int r = 0; r < 12; r++) begin
            clear_stim();
            s_len = $urandom_range(5, 40);
            pc = $urandom_range(0, 255) << 2;
            for (int k = 0; k < s_len; k++) begin
                if (k > 0 && $urandom_range(0, 1) == 0) pc = pc + 32'd4;
                s_pc[k] = pc;
                s_instr[k] = ($urandom_range(0, 29) == 0) ? SYS : ($urandom | 32'h100);
                s_wb[k] = ($urandom_range(0, 9) < 7);
                s_addr[k] = 5'($urandom_range(0, 31));
                s_data[k] = $urandom;
            end
            s_instr[s_len-1] = SYS;
            model(0, MAXC0); model(1, MAXC1);
            drive_run();
            verify_against_model("random");
        end
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_loop();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
